fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V core, directly upstream of the decoder. It owns the PC, issues in-order word requests to instruction memory over a valid/ready handshake and buffers returned words in a small queue. The decode stage pops the queue as a {pc, instruction} stream. Branch/jump redirects from execute flush the queue and discard responses that are still in flight.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the decoder.
//
// Owns the PC, issues in-order word fetches to instruction memory over a
// valid/ready handshake, and buffers returned words with their PCs in a small
// registered queue that decode pops as a {pc, instr} stream. Redirects from
// execute flush the queue and discard responses still in flight.
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to add the fetch_misalign
// output. A misaligned redirect target then halts fetching until the next
// aligned redirect. Without it, redirect_pc[1:0] is forced to 2'b00.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       fetch request handshake, word address
//   imem_resp_valid/data            in-order response word
//   dec_valid/ready/instr/pc        queue head towards decode
//   redirect_valid/pc               branch/jump redirect from execute
//   fetch_misalign                  (FETCH_ALIGN_CHECK_EN only) halted on
//                                   a misaligned redirect target
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  logic          started_q, started_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]   q_pc_q    [QUEUE_DEPTH];
  logic [31:0]   q_pc_d    [QUEUE_DEPTH];
  logic [31:0]   q_instr_q [QUEUE_DEPTH];
  logic [31:0]   q_instr_d [QUEUE_DEPTH];
  logic [31:0]   tag_q     [QUEUE_DEPTH];
  logic [31:0]   tag_d     [QUEUE_DEPTH];

  logic          halt;
  logic [31:0]   redirect_target;
  logic          req_fire, deq, enq;
  logic [CW:0]   credit_used;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign halt            = misalign_q;
  assign redirect_target = redirect_pc;
  assign fetch_misalign  = misalign_q;
`else
  assign halt            = 1'b0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // A dequeue in this cycle frees its slot in time for a response one cycle
  // later, so it is credited here; this is what allows one instruction per
  // cycle with a two-entry queue and single-cycle memory.
  assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q} - (CW+1)'(deq);
  assign imem_req_valid = started_q && !redirect_valid && !halt && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign dec_valid      = (count_q != '0);
  assign dec_pc         = q_pc_q[head_q];
  assign dec_instr      = q_instr_q[head_q];

  always_comb begin
    req_fire = imem_req_valid && imem_req_ready;
    deq      = dec_valid && dec_ready;
    // A response landing in a redirect cycle belongs to the old stream.
    enq      = imem_resp_valid && (drop_q == '0) && !redirect_valid;

    started_d     = 1'b1;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    drop_d        = drop_q;
    count_d       = count_q + CW'(enq) - CW'(deq);
    head_d        = head_q + PW'(deq);
    tail_d        = tail_q + PW'(enq);
    tag_wr_d      = tag_wr_q + PW'(req_fire);
    tag_rd_d      = tag_rd_q + PW'(enq);
    q_pc_d        = q_pc_q;
    q_instr_d     = q_instr_q;
    tag_d         = tag_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif

    if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;

    if (req_fire) begin
      pc_d            = pc_q + 32'd4;
      tag_d[tag_wr_q] = pc_q;
    end

    if (enq) begin
      q_pc_d[tail_q]    = tag_q[tag_rd_q];
      q_instr_d[tail_q] = imem_resp_data;
    end

    if (redirect_valid) begin
      pc_d     = redirect_target;
      // Every request still outstanding after this cycle is stale.
      drop_d   = outstanding_d;
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d = |redirect_pc[1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      q_pc_q        <= '{default: '0};
      q_instr_q     <= '{default: '0};
      tag_q         <= '{default: '0};
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      started_q     <= started_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      q_pc_q        <= q_pc_d;
      q_instr_q     <= q_instr_d;
      tag_q         <= tag_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Memory model: in-order responses, 'lat' cycles after acceptance.
  int          lat = 1;
  int          cyc = 0;
  int          due_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      due_q.delete();
      addr_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
      cyc             <= 0;
    end else begin
      cyc <= cyc + 1;
      if (imem_resp_valid) begin
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        due_q.push_back(cyc + lat);
        addr_q.push_back(imem_req_addr);
        acc_log.push_back(imem_req_addr);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= mem_word(addr_q[0]);
      end else begin
        imem_resp_valid <= 1'b0;
      end
      if (dec_valid && dec_ready) begin
        pop_pc.push_back(dec_pc);
        pop_instr.push_back(dec_instr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h100);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif

    // Reset release and streaming from RESET_PC
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_first_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h100);
    check("first_dec_valid", 32'(dec_valid), 32'd0);
    step();
    check("second_req_addr", imem_req_addr, 32'h104);
    check("e2_dec_valid", 32'(dec_valid), 32'd0);
    step();
    for (int k = 0; k < 6; k++) begin
      check("stream_dec_valid", 32'(dec_valid), 32'd1);
      check("stream_dec_pc", dec_pc, 32'h100 + 32'(4 * k));
      check("stream_dec_instr", dec_instr, mem_word(32'h100 + 32'(4 * k)));
      step();
    end

    // Redirect coinciding with a response and a dec handshake
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check("redir_req_valid", 32'(imem_req_valid), 32'd0);
    check("redir_dec_pc", dec_pc, 32'h118);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("redir_last_pop", pop_pc[pop_pc.size()-1], 32'h118);
    check("redir_pop_count", 32'(pop_pc.size()), 32'd7);
    check("redir_t1_dec_valid", 32'(dec_valid), 32'd0);
    check("redir_t1_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_t1_req_addr", imem_req_addr, 32'h200);
    acc_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    step();
    check("redir_t2_dec_valid", 32'(dec_valid), 32'd0);
    step();
    check("redir_t3_dec_valid", 32'(dec_valid), 32'd1);
    check("redir_t3_dec_pc", dec_pc, 32'h200);

    // Decoder stall for 10 cycles
    repeat (4) step();
    dec_ready = 1'b0;
    n0 = acc_log.size();
    repeat (10) step();
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_accepts_le_depth", 32'((acc_log.size() - n0) <= 2), 32'd1);
    check("stall_dec_valid", 32'(dec_valid), 32'd1);
    check("stall_head_pc", dec_pc, 32'h200 + 32'(4 * pop_pc.size()));
    dec_ready = 1'b1;

    // Memory ready toggling every cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_req_ready = ~imem_req_ready;
    end
    @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (8) step();
    check("drain_dec_valid", 32'(dec_valid), 32'd0);
    check("seq_count_match", 32'(pop_pc.size()), 32'(acc_log.size()));
    for (int i = 0; i < acc_log.size(); i++)
      check("acc_seq", acc_log[i], 32'h200 + 32'(4 * i));
    for (int i = 0; i < pop_pc.size(); i++) begin
      check("pop_seq_pc", pop_pc[i], 32'h200 + 32'(4 * i));
      check("pop_seq_instr", pop_instr[i], mem_word(32'h200 + 32'(4 * i)));
    end

    // Slow memory: two requests in flight, then redirect drops both
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h180;
    lat            = 4;
    acc_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    #1;
    check("slow_t0_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("slow_t1_req_addr", imem_req_addr, 32'h180);
    check("slow_t1_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    check("slow_t2_req_addr", imem_req_addr, 32'h184);
    check("slow_t2_req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check("slow_t3_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("slow_t4_req_valid", 32'(imem_req_valid), 32'd0);
    check("slow_t4_req_addr", imem_req_addr, 32'h200);
    step();
    check("slow_t5_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    check("slow_t6_req_valid", 32'(imem_req_valid), 32'd1);
    for (int i = 7; i <= 10; i++) begin
      step();
      check("slow_dec_valid_low", 32'(dec_valid), 32'd0);
    end
    step();
    check("slow_t11_dec_valid", 32'(dec_valid), 32'd1);
    check("slow_t11_dec_pc", dec_pc, 32'h200);
    check("slow_no_stale_pop", 32'(pop_pc.size()), 32'd0);
    check("slow_acc_after_drop", acc_log[2], 32'h200);

    // Misaligned redirect target
    @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (10) step();
    lat = 1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    imem_req_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_flag_set", 32'(fetch_misalign), 32'd1);
    check("mis_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (4) step();
    check("mis_req_valid_held", 32'(imem_req_valid), 32'd0);
    check("mis_flag_held", 32'(fetch_misalign), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("mis_flag_clear", 32'(fetch_misalign), 32'd0);
    check("mis_resume_valid", 32'(imem_req_valid), 32'd1);
    check("mis_resume_addr", imem_req_addr, 32'h300);
    repeat (2) step();
    check("mis_resume_dec_pc", dec_pc, 32'h300);
`else
    check("align_req_valid", 32'(imem_req_valid), 32'd1);
    check("align_req_addr", imem_req_addr, 32'h200);
    repeat (2) step();
    check("align_dec_valid", 32'(dec_valid), 32'd1);
    check("align_dec_pc", dec_pc, 32'h200);
`endif

    // Asynchronous reset mid-stream
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", imem_req_addr, 32'h100);
    check("midrst_dec_valid", 32'(dec_valid), 32'd0);
    check("midrst_dec_pc", dec_pc, 32'h0);
    check("midrst_dec_instr", dec_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("midrst_first_req", imem_req_addr, 32'h100);
    repeat (2) step();
    check("midrst_first_dec_valid", 32'(dec_valid), 32'd1);
    check("midrst_first_dec_pc", dec_pc, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
